// File: rtl/sopc_2_cpu_debug_jtag_pkg.sv
// Shared types and constants for the CPU debug virtual-JTAG master.
package sopc_2_cpu_debug_jtag_pkg;

  localparam int unsigned DEBUG_SR_W = 38;
  localparam int unsigned DEBUG_IR_W = 2;

  localparam logic [DEBUG_IR_W-1:0] IR_OCIMEM    = 2'b00;
  localparam logic [DEBUG_IR_W-1:0] IR_TRACECTRL = 2'b01;
  localparam logic [DEBUG_IR_W-1:0] IR_BREAK     = 2'b10;
  localparam logic [DEBUG_IR_W-1:0] IR_TRACEMEM  = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_UIR,
    ST_CDR,
    ST_SDR,
    ST_UDR,
    ST_RTI,
    ST_RESP
  } state_e;

  // One-hot virtual TAP state strobes
  typedef struct packed {
    logic uir;
    logic cdr;
    logic sdr;
    logic udr;
    logic rti;
  } vji_strobe_t;

  localparam vji_strobe_t STRB_NONE = vji_strobe_t'(5'b00000);
  localparam vji_strobe_t STRB_UIR  = vji_strobe_t'(5'b10000);
  localparam vji_strobe_t STRB_CDR  = vji_strobe_t'(5'b01000);
  localparam vji_strobe_t STRB_SDR  = vji_strobe_t'(5'b00100);
  localparam vji_strobe_t STRB_UDR  = vji_strobe_t'(5'b00010);
  localparam vji_strobe_t STRB_RTI  = vji_strobe_t'(5'b00001);

endpackage

// File: rtl/sopc_2_cpu_debug_jtag_master_if.sv
// Command/response handshake plus virtual-JTAG pins between the master and its environment.
interface sopc_2_cpu_debug_jtag_master_if #(
  parameter int unsigned DATA_W = 38,
  parameter int unsigned IR_W   = 2
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic [IR_W-1:0]   cmd_ir;
  logic [DATA_W-1:0] cmd_data;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_data;
  logic [IR_W-1:0]   rsp_ir_out;
  logic              vji_tck;
  logic              vji_tdi;
  logic              vji_tdo;
  logic [IR_W-1:0]   vji_ir_in;
  logic [IR_W-1:0]   vji_ir_out;
  logic              vji_uir;
  logic              vji_cdr;
  logic              vji_sdr;
  logic              vji_udr;
  logic              vji_rti;

  modport master (
    input  cmd_valid, cmd_ir, cmd_data, rsp_ready, vji_tdo, vji_ir_out,
    output cmd_ready, rsp_valid, rsp_data, rsp_ir_out,
    output vji_tck, vji_tdi, vji_ir_in, vji_uir, vji_cdr, vji_sdr, vji_udr, vji_rti
  );

  modport slave (
    output cmd_valid, cmd_ir, cmd_data, rsp_ready, vji_tdo, vji_ir_out,
    input  cmd_ready, rsp_valid, rsp_data, rsp_ir_out,
    input  vji_tck, vji_tdi, vji_ir_in, vji_uir, vji_cdr, vji_sdr, vji_udr, vji_rti
  );
endinterface

// File: rtl/sopc_2_cpu_debug_tck_gen.sv
// TCK divider: TCK_DIV clk low then TCK_DIV clk high per period, parked low when disabled.
module sopc_2_cpu_debug_tck_gen #(
  parameter int unsigned TCK_DIV = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  output logic tck,
  output logic rise_pulse_c,
  output logic fall_pulse_c
);
  localparam int unsigned      CNT_W    = $clog2(TCK_DIV) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TCK_DIV - 1);

  logic [CNT_W-1:0] cnt;
  logic             wrap_c;

  // Pulses flag the clk edge on which tck will toggle
  assign wrap_c       = en && (cnt == CNT_LAST);
  assign rise_pulse_c = wrap_c && !tck;
  assign fall_pulse_c = wrap_c && tck;

  always_ff @(posedge clk) begin
    if (reset || !en) begin
      cnt <= '0;
      tck <= 1'b0;
    end else if (wrap_c) begin
      cnt <= '0;
      tck <= ~tck;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end
endmodule

// File: rtl/sopc_2_cpu_debug_jtag_master.sv
// Virtual-JTAG host: runs one UIR/CDR/SDR/UDR/RTI scan per accepted command and returns captured tdo.
module sopc_2_cpu_debug_jtag_master
  import sopc_2_cpu_debug_jtag_pkg::*;
#(
  parameter int unsigned DATA_W       = DEBUG_SR_W,
  parameter int unsigned IR_W         = DEBUG_IR_W,
  parameter int unsigned TCK_DIV      = 2,
  parameter int unsigned RTI_CYCLES   = 1,
  parameter int unsigned SKIP_SAME_IR = 1
) (
  input logic clk,
  input logic reset,
  sopc_2_cpu_debug_jtag_master_if.master bus
);
  localparam int unsigned      BIT_W    = $clog2(DATA_W);
  localparam int unsigned      RTI_W    = $clog2(RTI_CYCLES) + 1;
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_W - 1);
  localparam logic [RTI_W-1:0] RTI_LAST = RTI_W'(RTI_CYCLES - 1);

  state_e            state;
  vji_strobe_t       strb;
  logic              cmd_ready;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_data;
  logic [IR_W-1:0]   rsp_ir_out;
  logic              tdi;
  logic [IR_W-1:0]   ir_in;
  logic              ir_valid;
  logic [DATA_W-1:0] sh;
  logic [BIT_W-1:0]  bit_cnt;
  logic [RTI_W-1:0]  rti_cnt;
  logic              tck;
  logic              tck_en_c;
  logic              rise_c;
  logic              fall_c;
  logic              skip_c;

  assign tck_en_c = (state != ST_IDLE) && (state != ST_RESP);
  assign skip_c   = (SKIP_SAME_IR != 0) && ir_valid && (bus.cmd_ir == ir_in);

  sopc_2_cpu_debug_tck_gen #(.TCK_DIV(TCK_DIV)) u_tck_gen (
    .clk          (clk),
    .reset        (reset),
    .en           (tck_en_c),
    .tck          (tck),
    .rise_pulse_c (rise_c),
    .fall_pulse_c (fall_c)
  );

  // Scan sequencer; states change only on the edge where tck returns low
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      strb       <= STRB_NONE;
      cmd_ready  <= 1'b0;
      rsp_valid  <= 1'b0;
      rsp_data   <= '0;
      rsp_ir_out <= '0;
      tdi        <= 1'b0;
      ir_in      <= '0;
      ir_valid   <= 1'b0;
      sh         <= '0;
      bit_cnt    <= '0;
      rti_cnt    <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          cmd_ready <= 1'b1;
          if (bus.cmd_valid && cmd_ready) begin
            cmd_ready <= 1'b0;
            sh        <= bus.cmd_data;
            if (skip_c) begin
              state <= ST_CDR;
              strb  <= STRB_CDR;
            end else begin
              state <= ST_UIR;
              strb  <= STRB_UIR;
              ir_in <= bus.cmd_ir;
            end
          end
        end
        ST_UIR: begin
          if (rise_c) rsp_ir_out <= bus.vji_ir_out;
          if (fall_c) begin
            state    <= ST_CDR;
            strb     <= STRB_CDR;
            ir_valid <= 1'b1;
          end
        end
        ST_CDR: begin
          if (fall_c) begin
            state   <= ST_SDR;
            strb    <= STRB_SDR;
            tdi     <= sh[0];
            sh      <= sh >> 1;
            bit_cnt <= '0;
          end
        end
        ST_SDR: begin
          // tdo sampled ahead of the slave's posedge shift
          if (rise_c) rsp_data <= {bus.vji_tdo, rsp_data[DATA_W-1:1]};
          if (fall_c) begin
            if (bit_cnt == BIT_LAST) begin
              state <= ST_UDR;
              strb  <= STRB_UDR;
              tdi   <= 1'b0;
            end else begin
              bit_cnt <= bit_cnt + BIT_W'(1);
              tdi     <= sh[0];
              sh      <= sh >> 1;
            end
          end
        end
        ST_UDR: begin
          if (fall_c) begin
            state   <= ST_RTI;
            strb    <= STRB_RTI;
            rti_cnt <= '0;
          end
        end
        ST_RTI: begin
          if (fall_c) begin
            if (rti_cnt == RTI_LAST) begin
              state     <= ST_RESP;
              strb      <= STRB_NONE;
              rsp_valid <= 1'b1;
            end else begin
              rti_cnt <= rti_cnt + RTI_W'(1);
            end
          end
        end
        ST_RESP: begin
          if (bus.rsp_ready) begin
            state     <= ST_IDLE;
            rsp_valid <= 1'b0;
            cmd_ready <= 1'b1;
          end
        end
        default: begin
          state <= ST_IDLE;
          strb  <= STRB_NONE;
        end
      endcase
    end
  end

  assign bus.cmd_ready  = cmd_ready;
  assign bus.rsp_valid  = rsp_valid;
  assign bus.rsp_data   = rsp_data;
  assign bus.rsp_ir_out = rsp_ir_out;
  assign bus.vji_tck    = tck;
  assign bus.vji_tdi    = tdi;
  assign bus.vji_ir_in  = ir_in;
  assign bus.vji_uir    = strb.uir;
  assign bus.vji_cdr    = strb.cdr;
  assign bus.vji_sdr    = strb.sdr;
  assign bus.vji_udr    = strb.udr;
  assign bus.vji_rti    = strb.rti;
endmodule

// File: tb/tb_sopc_2_cpu_debug_jtag_master.sv
// Bench for the virtual-JTAG master: TCK_DIV=2 instance with command table, TCK_DIV=1 instance for loopback.
module tb_sopc_2_cpu_debug_jtag_master;
  import sopc_2_cpu_debug_jtag_pkg::*;

  localparam int unsigned DW = 38;
  localparam int unsigned IW = 2;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  sopc_2_cpu_debug_jtag_master_if #(.DATA_W(DW), .IR_W(IW)) bus0 ();
  sopc_2_cpu_debug_jtag_master_if #(.DATA_W(DW), .IR_W(IW)) bus1 ();

  sopc_2_cpu_debug_jtag_master #(.DATA_W(DW), .IR_W(IW), .TCK_DIV(2), .RTI_CYCLES(1), .SKIP_SAME_IR(1))
    dut0 (.clk(clk), .reset(reset), .bus(bus0.master));
  sopc_2_cpu_debug_jtag_master #(.DATA_W(DW), .IR_W(IW), .TCK_DIV(1), .RTI_CYCLES(1), .SKIP_SAME_IR(1))
    dut1 (.clk(clk), .reset(reset), .bus(bus1.master));

  // Debug-slave shift register models, shifting on tck rise while in SDR
  logic [DW-1:0] sr0, sr1, load_val0, load_val1;
  logic load0 = 1'b0, load1 = 1'b0;
  always @(posedge bus0.vji_tck or posedge load0)
    if (load0) sr0 <= load_val0;
    else if (bus0.vji_sdr) sr0 <= {bus0.vji_tdi, sr0[DW-1:1]};
  always @(posedge bus1.vji_tck or posedge load1)
    if (load1) sr1 <= load_val1;
    else if (bus1.vji_sdr) sr1 <= {bus1.vji_tdi, sr1[DW-1:1]};
  assign bus0.vji_tdo    = sr0[0];
  assign bus1.vji_tdo    = sr1[0];
  assign bus0.vji_ir_out = ~bus0.vji_ir_in;
  assign bus1.vji_ir_out = ~bus1.vji_ir_in;

  int uir0 = 0, sdr0 = 0, tckh1 = 0, viol1 = 0;
  logic ptck1 = 1'b0, ptdi1 = 1'b0;
  always @(negedge clk) begin
    if (bus0.vji_uir) uir0++;
    if (bus0.vji_sdr) sdr0++;
    if (bus1.vji_tck) tckh1++;
    if (bus1.vji_tck && !ptck1 && (bus1.vji_tdi !== ptdi1)) viol1++;
    ptck1 = bus1.vji_tck;
    ptdi1 = bus1.vji_tdi;
  end

  int n_pass = 0, n_chk = 0;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  typedef struct {
    logic [DW-1:0] data;
    logic [IW-1:0] ir_out;
    int            lat;
    int            uir;
  } exp_t;
  typedef struct {
    logic [IW-1:0] ir;
    logic [DW-1:0] data;
    logic          pre_en;
    logic [DW-1:0] pre;
    int            rdy_dly;
  } vec_t;

  exp_t sb[$];
  vec_t vecs[6];
  logic [DW-1:0] mir_sr = '0;
  logic [IW-1:0] mir_ir = '0, mir_ir_out = '0;
  logic          mir_irv = 1'b0;

  task automatic run0(input vec_t v);
    exp_t e, got;
    int lat, viol;
    bit do_uir;
    logic [DW-1:0] rd;
    if (v.pre_en) begin
      load_val0 = v.pre; load0 = 1'b1; #1 load0 = 1'b0;
      mir_sr = v.pre;
    end
    do_uir = !(mir_irv && (v.ir == mir_ir));
    if (do_uir) mir_ir_out = ~v.ir;
    e.data = mir_sr; e.ir_out = mir_ir_out; e.uir = do_uir ? 4 : 0;
    e.lat = ((do_uir ? 1 : 0) + 1 + DW + 1 + 1) * 4;
    sb.push_back(e);
    mir_sr = v.data; mir_ir = v.ir; mir_irv = 1'b1;

    lat = 0;
    while (!bus0.cmd_ready && lat < 50) begin @(posedge clk); #1; lat++; end
    chk("cmd_ready_before_send", bus0.cmd_ready, 1);
    bus0.cmd_valid = 1'b1; bus0.cmd_ir = v.ir; bus0.cmd_data = v.data;
    @(posedge clk); #1;
    bus0.cmd_valid = 1'b0; uir0 = 0; sdr0 = 0;
    lat = 0;
    while (!bus0.rsp_valid && lat < 2000) begin @(posedge clk); #1; lat++; end
    got = sb.pop_front();
    chk("latency", lat, got.lat);
    chk("uir_clks", uir0, got.uir);
    chk("sdr_clks", sdr0, DW * 4);
    chk("rsp_data", bus0.rsp_data, got.data);
    chk("rsp_ir_out", bus0.rsp_ir_out, got.ir_out);
    chk("vji_ir_in", bus0.vji_ir_in, v.ir);
    chk("slave_sr", sr0, v.data);

    rd = bus0.rsp_data; viol = 0;
    for (int i = 0; i < v.rdy_dly; i++) begin
      bus0.cmd_valid = (i == 5);
      @(posedge clk); #1;
      if (!bus0.rsp_valid || (bus0.rsp_data !== rd) || bus0.cmd_ready) viol++;
    end
    bus0.cmd_valid = 1'b0;
    if (v.rdy_dly > 0) chk("backpressure_hold", viol, 0);
    bus0.rsp_ready = 1'b1;
    @(posedge clk); #1;
    bus0.rsp_ready = 1'b0;
    chk("rsp_valid_drop", bus0.rsp_valid, 0);
    chk("cmd_ready_after_rsp", bus0.cmd_ready, 1);
    uir0 = 0;
    repeat (4) @(posedge clk); #1;
    chk("idle_after_rsp", {uir0 != 0, bus0.cmd_ready}, 2'b01);
  endtask

  initial begin
    int n;
    vecs[0] = '{IR_BREAK,     38'h00_0000_0001, 1'b1, 38'h2A_5A5A_A5A5, 0};
    vecs[1] = '{IR_BREAK,     38'h15_1234_5678, 1'b1, 38'h2A_5A5A_A5A5, 0};
    vecs[2] = '{IR_OCIMEM,    38'h3F_FFFF_FFFF, 1'b0, 38'h0,            0};
    vecs[3] = '{IR_OCIMEM,    38'h00_0000_0000, 1'b0, 38'h0,            3};
    vecs[4] = '{IR_TRACEMEM,  38'h2A_AAAA_AAAA, 1'b0, 38'h0,            20};
    vecs[5] = '{IR_TRACECTRL, 38'h15_5555_5555, 1'b0, 38'h0,            1};

    bus0.cmd_valid = 1'b0; bus0.cmd_ir = '0; bus0.cmd_data = '0; bus0.rsp_ready = 1'b0;
    bus1.cmd_valid = 1'b0; bus1.cmd_ir = '0; bus1.cmd_data = '0; bus1.rsp_ready = 1'b0;
    reset = 1'b1;
    repeat (3) @(posedge clk); #1;
    chk("rst_cmd_ready", bus0.cmd_ready, 0);
    chk("rst_rsp_valid", bus0.rsp_valid, 0);
    chk("rst_rsp_data", bus0.rsp_data, 0);
    chk("rst_rsp_ir_out", bus0.rsp_ir_out, 0);
    chk("rst_pins", {bus0.vji_tck, bus0.vji_tdi, bus0.vji_uir, bus0.vji_cdr,
                     bus0.vji_sdr, bus0.vji_udr, bus0.vji_rti}, 0);
    chk("rst_ir_in", bus0.vji_ir_in, 0);
    reset = 1'b0;
    @(posedge clk); #1;
    chk("cmd_ready_after_rst", bus0.cmd_ready, 1);

    for (int i = 0; i < 6; i++) run0(vecs[i]);

    // Reset in the middle of the SDR scan
    bus0.cmd_valid = 1'b1; bus0.cmd_ir = IR_TRACECTRL; bus0.cmd_data = 38'h0F_0F0F_0F0F;
    @(posedge clk); #1;
    bus0.cmd_valid = 1'b0;
    n = 0;
    while (!bus0.vji_sdr && n < 100) begin @(posedge clk); #1; n++; end
    repeat (17 * 4 + 2) @(posedge clk); #1;
    chk("sdr_before_reset", bus0.vji_sdr, 1);
    reset = 1'b1;
    @(posedge clk); #1;
    chk("midscan_rst_pins", {bus0.vji_tck, bus0.vji_tdi, bus0.vji_uir, bus0.vji_cdr,
                             bus0.vji_sdr, bus0.vji_udr, bus0.vji_rti}, 0);
    chk("midscan_rst_rsp", {bus0.rsp_valid, bus0.cmd_ready}, 0);
    reset = 1'b0;
    @(posedge clk); #1;
    chk("midscan_cmd_ready", bus0.cmd_ready, 1);
    mir_irv = 1'b0; mir_ir_out = '0;
    run0('{IR_TRACECTRL, 38'h0A_BCDE_F012, 1'b1, 38'h05_4321_0FED, 0});

    // TCK_DIV=1 loopback
    load_val1 = 38'h2A_5A5A_A5A5; load1 = 1'b1; #1 load1 = 1'b0;
    n = 0;
    while (!bus1.cmd_ready && n < 50) begin @(posedge clk); #1; n++; end
    bus1.cmd_valid = 1'b1; bus1.cmd_ir = IR_BREAK; bus1.cmd_data = 38'h15_1234_5678;
    @(posedge clk); #1;
    bus1.cmd_valid = 1'b0; tckh1 = 0; viol1 = 0;
    n = 0;
    while (!bus1.rsp_valid && n < 1000) begin @(posedge clk); #1; n++; end
    chk("div1_latency", n, 84);
    chk("div1_rsp_data", bus1.rsp_data, 38'h2A_5A5A_A5A5);
    chk("div1_tck_high", tckh1, 42);
    chk("div1_tdi_stable", viol1, 0);
    chk("div1_slave_sr", sr1, 38'h15_1234_5678);
    bus1.rsp_ready = 1'b1;
    @(posedge clk); #1;
    bus1.rsp_ready = 1'b0;
    chk("div1_cmd_ready", bus1.cmd_ready, 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
